// File: rtl/vga_timing_pkg.sv
// 640x480@60 beam timing constants and the line-fetch FSM state encoding,
// shared between vga_controller and vga_line_fetch_arbiter.
package vga_timing_pkg;

    localparam int unsigned W_DISPLAY = 640;
    localparam int unsigned W_FRONT   = 16;
    localparam int unsigned W_SYNC    = 96;
    localparam int unsigned W_BACK    = 48;
    localparam int unsigned W_MAX     = W_DISPLAY + W_FRONT + W_SYNC + W_BACK - 1;

    localparam int unsigned H_DISPLAY = 480;
    localparam int unsigned H_FRONT   = 10;
    localparam int unsigned H_SYNC    = 2;
    localparam int unsigned H_BACK    = 33;
    localparam int unsigned H_MAX     = H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1;

    typedef enum logic [1:0] {
        StIdle,
        StPrefetch,
        StDrain,
        StHost
    } fetch_state_e;

endpackage

// File: rtl/vga_line_addr.sv
// Next-line computation: which display line follows the beam, whether the current pixel
// starts its prefetch, and the RAM base address of that line's tile row.
module vga_line_addr
    import vga_timing_pkg::*;
#(
    parameter int unsigned AW             = 12,
    parameter int unsigned WORDS_PER_LINE = 40,
    parameter int unsigned ROW_SHIFT      = 3,
    parameter int unsigned LINE_BASE      = 0
) (
    input  logic [9:0]    x_i,
    input  logic [9:0]    y_i,
    output logic          trigger_o,
    output logic [AW-1:0] base_o
);

    logic [9:0] nxt;

    assign nxt       = (y_i == 10'(H_MAX)) ? 10'd0 : y_i + 10'd1;
    assign trigger_o = (x_i == 10'(W_DISPLAY)) && (nxt < 10'(H_DISPLAY));
    // Wraps modulo 2^AW by construction of the cast.
    assign base_o    = AW'(LINE_BASE + ((32'(nxt) >> ROW_SHIFT) * WORDS_PER_LINE));

endmodule

// File: rtl/vga_line_fetch_arbiter.sv
// Arbitrates a single-port RAM between the hblank scanline prefetcher, which fills a
// double-banked line buffer, and a host port that is only served outside prefetch windows.
module vga_line_fetch_arbiter
    import vga_timing_pkg::*;
#(
    parameter int unsigned AW             = 12,
    parameter int unsigned DW             = 16,
    parameter int unsigned WORDS_PER_LINE = 40,
    parameter int unsigned ROW_SHIFT      = 3,
    parameter int unsigned LINE_BASE      = 0,
    parameter int unsigned LBW            = $clog2(WORDS_PER_LINE)
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic [9:0]    x_i,
    input  logic [9:0]    y_i,
    input  logic          host_req_i,
    input  logic          host_we_i,
    input  logic [AW-1:0] host_addr_i,
    input  logic [DW-1:0] host_wdata_i,
    output logic          host_gnt_o,
    output logic          host_rvalid_o,
    output logic [DW-1:0] host_rdata_o,
    output logic          mem_re_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic [DW-1:0] mem_rdata_i,
    output logic          lb_we_o,
    output logic [LBW:0]  lb_waddr_o,
    output logic [DW-1:0] lb_wdata_o,
    output logic          disp_bank_o,
    output logic          busy_o,
    output logic          underrun_o
);

    // One spare bit so the counter can hold WORDS_PER_LINE itself.
    localparam int unsigned    IW       = LBW + 1;
    localparam logic [IW-1:0]  LAST_IDX = IW'(WORDS_PER_LINE);

    logic          trigger;
    logic [AW-1:0] base;

    vga_line_addr #(
        .AW             (AW),
        .WORDS_PER_LINE (WORDS_PER_LINE),
        .ROW_SHIFT      (ROW_SHIFT),
        .LINE_BASE      (LINE_BASE)
    ) u_line_addr (
        .x_i       (x_i),
        .y_i       (y_i),
        .trigger_o (trigger),
        .base_o    (base)
    );

    fetch_state_e  state_q;
    logic [IW-1:0] idx_q;
    logic [LBW-1:0] rd_idx_q;
    logic [AW-1:0] base_q;
    logic          wbank_q;
    logic          host_gnt_q, host_rvalid_q, mem_re_q, mem_we_q;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_wdata_q;
    logic          lb_we_q;
    logic [LBW:0]  lb_waddr_q;
    logic          disp_bank_q, busy_q, underrun_q;

    always_ff @(posedge clk_i) begin
        if (rst_n_i) begin
            state_q       <= StIdle;
            idx_q         <= '0;
            rd_idx_q      <= '0;
            base_q        <= '0;
            wbank_q       <= 1'b0;
            host_gnt_q    <= 1'b0;
            host_rvalid_q <= 1'b0;
            mem_re_q      <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            lb_we_q       <= 1'b0;
            lb_waddr_q    <= '0;
            disp_bank_q   <= 1'b0;
            busy_q        <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            // Only prefetch reads land in the line buffer; host reads never overlap busy.
            lb_we_q       <= mem_re_q && busy_q;
            lb_waddr_q    <= {wbank_q, rd_idx_q};
            host_rvalid_q <= 1'b0;
            if (busy_q && (x_i == 10'(W_MAX))) begin
                underrun_q <= 1'b1;
            end
            unique case (state_q)
                StIdle: begin
                    if (trigger) begin
                        state_q     <= StPrefetch;
                        wbank_q     <= ~wbank_q;
                        disp_bank_q <= wbank_q;
                        base_q      <= base;
                        mem_re_q    <= 1'b1;
                        mem_addr_q  <= base;
                        rd_idx_q    <= '0;
                        idx_q       <= IW'(1);
                        busy_q      <= 1'b1;
                    end else if (host_req_i) begin
                        state_q     <= StHost;
                        host_gnt_q  <= 1'b1;
                        mem_addr_q  <= host_addr_i;
                        mem_wdata_q <= host_wdata_i;
                        mem_we_q    <= host_we_i;
                        mem_re_q    <= ~host_we_i;
                    end
                end
                StPrefetch: begin
                    if (idx_q == LAST_IDX) begin
                        state_q  <= StDrain;
                        mem_re_q <= 1'b0;
                    end else begin
                        mem_re_q   <= 1'b1;
                        mem_addr_q <= base_q + AW'(idx_q);
                        rd_idx_q   <= LBW'(idx_q);
                        idx_q      <= idx_q + IW'(1);
                    end
                end
                StDrain: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                StHost: begin
                    state_q       <= StIdle;
                    host_gnt_q    <= 1'b0;
                    host_rvalid_q <= mem_re_q;
                    mem_re_q      <= 1'b0;
                    mem_we_q      <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign host_gnt_o    = host_gnt_q;
    assign host_rvalid_o = host_rvalid_q;
    assign host_rdata_o  = mem_rdata_i;
    assign mem_re_o      = mem_re_q;
    assign mem_we_o      = mem_we_q;
    assign mem_addr_o    = mem_addr_q;
    assign mem_wdata_o   = mem_wdata_q;
    assign lb_we_o       = lb_we_q;
    assign lb_waddr_o    = lb_waddr_q;
    assign lb_wdata_o    = mem_rdata_i;
    assign disp_bank_o   = disp_bank_q;
    assign busy_o        = busy_q;
    assign underrun_o    = underrun_q;

endmodule
